// File: rtl/lepton_lb_pkg.sv
// lepton_lb_pkg: shared constants, write FSM encoding and address-width helper for the Lepton line buffer
package lepton_lb_pkg;
    localparam int HSIZE_DEF    = 160;
    localparam int VSIZE_DEF    = 120;
    localparam int NBUFFERS_DEF = 4;
    localparam int IDX_W_DEF    = 9;

    typedef enum logic [1:0] {IDLE, FILL, GAP} state_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/lepton_line_buffer_ram.sv
// line_ram: simple dual-port RAM, synchronous write, registered read returning old data on collision
module line_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // write and registered read share the edge so a colliding read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lepton_line_buffer.sv
// lepton_line_buffer: ring of line buffers filled from the Lepton pixel stream, random-access read port for the LCD writer
module lepton_line_buffer
    import lepton_lb_pkg::*;
#(
    parameter int HSIZE    = HSIZE_DEF,
    parameter int VSIZE    = VSIZE_DEF,
    parameter int NBUFFERS = NBUFFERS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             pix_valid_in,
    input  logic [23:0]      pix_data_in,
    input  logic             sof_in,
    input  logic             sol_in,
    input  logic [IDX_W-1:0] nbuff_in,
    input  logic [IDX_W-1:0] npixel_in,
    input  logic             clr_err_in,
    output logic [23:0]      pixel_out,
    output logic [IDX_W-1:0] busybuff_out,
    output logic [IDX_W-1:0] filledbuff_out,
    output logic             fsync_out,
    output logic             frame_active_out,
    output logic             line_err_out
);
    localparam int AW = addr_w(NBUFFERS * HSIZE);
    localparam int LW = $clog2(VSIZE + 1);
    localparam logic [IDX_W-1:0] NB_L   = IDX_W'(NBUFFERS);
    localparam logic [IDX_W-1:0] HS_L   = IDX_W'(HSIZE);
    localparam logic [IDX_W-1:0] LAST_B = IDX_W'(NBUFFERS - 1);
    localparam logic [IDX_W-1:0] LAST_P = IDX_W'(HSIZE - 1);
    localparam logic [LW-1:0]    LAST_L = LW'(VSIZE - 1);
    localparam logic [LW-1:0]    FULL_L = LW'(VSIZE);

    logic [1:0]       rsync;
    logic             rst_n;
    state_t           state;
    logic [IDX_W-1:0] wpix;
    logic [LW-1:0]    line_cnt;
    logic             sof_hit, we, rd_in_range, rd_ok;
    logic [IDX_W-1:0] wbuf, wp;
    logic [AW-1:0]    waddr, raddr;
    logic [23:0]      rdata;

    // reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) rsync <= 2'b00;
        else             rsync <= {rsync[0], 1'b1};
    end
    assign rst_n = rsync[1];

    // write-side decode: which pixels land in RAM and where
    always_comb begin
        sof_hit     = pix_valid_in & sof_in;
        we          = sof_hit | (pix_valid_in & (state == FILL)) | (pix_valid_in & sol_in & (state == GAP));
        wbuf        = sof_hit ? '0 : busybuff_out;
        wp          = (sof_in | sol_in) ? '0 : wpix;
        waddr       = AW'(wbuf) * AW'(HSIZE) + AW'(wp);
        rd_in_range = (nbuff_in < NB_L) && (npixel_in < HS_L);
        raddr       = rd_in_range ? AW'(nbuff_in) * AW'(HSIZE) + AW'(npixel_in) : '0;
    end

    // write FSM: tracks pixel/line position, rotates buffers and flags malformed lines
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wpix             <= '0;
            line_cnt         <= '0;
            busybuff_out     <= '0;
            filledbuff_out   <= LAST_B;
            fsync_out        <= 1'b0;
            frame_active_out <= 1'b0;
            line_err_out     <= 1'b0;
        end else begin
            fsync_out <= 1'b0;
            if (clr_err_in) line_err_out <= 1'b0;
            if (sof_hit) begin
                if (state != IDLE && line_cnt != FULL_L) line_err_out <= 1'b1;
                busybuff_out     <= '0;
                wpix             <= IDX_W'(1);
                line_cnt         <= '0;
                frame_active_out <= 1'b1;
                state            <= FILL;
            end else if (pix_valid_in) begin
                case (state)
                    FILL: begin
                        if (sol_in) begin
                            line_err_out <= 1'b1;
                            wpix         <= IDX_W'(1);
                        end else if (wpix == LAST_P) begin
                            filledbuff_out <= busybuff_out;
                            busybuff_out   <= (busybuff_out == LAST_B) ? '0 : busybuff_out + 1'b1;
                            line_cnt       <= line_cnt + 1'b1;
                            fsync_out      <= (line_cnt == '0);
                            state          <= (line_cnt == LAST_L) ? IDLE : GAP;
                            if (line_cnt == LAST_L) frame_active_out <= 1'b0;
                        end else begin
                            wpix <= wpix + 1'b1;
                        end
                    end
                    GAP: begin
                        if (sol_in) begin
                            wpix  <= IDX_W'(1);
                            state <= FILL;
                        end else begin
                            line_err_out <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // remembers whether the pending read was in range so stray indices read back as zero
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) rd_ok <= 1'b0;
        else        rd_ok <= rd_in_range;
    end

    assign pixel_out = rd_ok ? rdata : '0;

    line_ram #(
        .DEPTH(NBUFFERS * HSIZE),
        .AW   (AW),
        .DW   (24)
    ) u_ram (
        .clk  (clk_in),
        .we   (we),
        .waddr(waddr),
        .wdata(pix_data_in),
        .raddr(raddr),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_lepton_line_buffer.sv
// tb_lepton_line_buffer: directed checks of frame filling, buffer rotation, readback and error handling
module tb_lepton_line_buffer;
    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        pix_valid_in, sof_in, sol_in, clr_err_in;
    logic [23:0] pix_data_in;
    logic [8:0]  nbuff_in, npixel_in;
    logic [23:0] pixel_out;
    logic [8:0]  busybuff_out, filledbuff_out;
    logic        fsync_out, frame_active_out, line_err_out;
    int          passes = 0;
    int          total = 0;
    int          fsync_cnt = 0;
    int          base;

    lepton_line_buffer dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .pix_valid_in    (pix_valid_in),
        .pix_data_in     (pix_data_in),
        .sof_in          (sof_in),
        .sol_in          (sol_in),
        .nbuff_in        (nbuff_in),
        .npixel_in       (npixel_in),
        .clr_err_in      (clr_err_in),
        .pixel_out       (pixel_out),
        .busybuff_out    (busybuff_out),
        .filledbuff_out  (filledbuff_out),
        .fsync_out       (fsync_out),
        .frame_active_out(frame_active_out),
        .line_err_out    (line_err_out)
    );

    always #5 clk_in = ~clk_in;

    // counts fsync pulses, sampled midway between active edges
    always @(negedge clk_in) if (fsync_out === 1'b1) fsync_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [23:0] d, input logic sf, input logic sl);
        pix_valid_in = v;
        pix_data_in  = d;
        sof_in       = sf;
        sol_in       = sl;
        @(posedge clk_in);
        #1;
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        sol_in       = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] tag, input int from, input int to, input logic sf);
        for (int x = from; x <= to; x++) drive(1'b1, {8'h00, tag, 8'(x)}, sf && x == 0, x == 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pixel"}, 32'(pixel_out), 32'h0);
        check({tag, "_busy"}, 32'(busybuff_out), 32'd0);
        check({tag, "_filled"}, 32'(filledbuff_out), 32'd3);
        check({tag, "_fsync"}, 32'(fsync_out), 32'd0);
        check({tag, "_fa"}, 32'(frame_active_out), 32'd0);
        check({tag, "_err"}, 32'(line_err_out), 32'd0);
    endtask

    initial begin
        reset_n_in   = 1'b0;
        pix_valid_in = 1'b0;
        sof_in       = 1'b0;
        sol_in       = 1'b0;
        clr_err_in   = 1'b0;
        pix_data_in  = '0;
        nbuff_in     = '0;
        npixel_in    = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_state("por");
        reset_n_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;

        send_range(8'd0, 0, 159, 1'b1);
        check("l0_fsync", 32'(fsync_out), 32'd1);
        check("l0_filled", 32'(filledbuff_out), 32'd0);
        send_range(8'd1, 0, 49, 1'b0);
        check("mid_busy", 32'(busybuff_out), 32'd1);
        #1 reset_n_in = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk_in);
        #1 reset_n_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;

        base = fsync_cnt;
        for (int l = 0; l < 120; l++) begin
            send_range(8'(l), 0, 159, l == 0);
            if (l == 0) begin
                check("ff_fsync_hi", 32'(fsync_out), 32'd1);
                check("ff_fa", 32'(frame_active_out), 32'd1);
            end
            check("ff_filled", 32'(filledbuff_out), 32'(l % 4));
            if (l == 6) begin
                nbuff_in  = 9'd2;
                npixel_in = 9'd17;
                drive(1'b0, '0, 1'b0, 1'b0);
                check("rd_2_17", 32'(pixel_out), 32'h000611);
                npixel_in = 9'd160;
                drive(1'b0, '0, 1'b0, 1'b0);
                check("rd_pix160", 32'(pixel_out), 32'h0);
                nbuff_in  = 9'd4;
                npixel_in = 9'd0;
                drive(1'b0, '0, 1'b0, 1'b0);
                check("rd_buf4", 32'(pixel_out), 32'h0);
                nbuff_in  = 9'd0;
            end
            drive(1'b0, '0, 1'b0, 1'b0);
            if (l == 0) check("ff_fsync_lo", 32'(fsync_out), 32'd0);
        end
        check("ff_fsync_cnt", 32'(fsync_cnt - base), 32'd1);
        check("ff_end_filled", 32'(filledbuff_out), 32'd3);
        check("ff_end_busy", 32'(busybuff_out), 32'd0);
        check("ff_end_fa", 32'(frame_active_out), 32'd0);
        check("ff_end_err", 32'(line_err_out), 32'd0);

        send_range(8'd0, 0, 159, 1'b1);
        send_range(8'd1, 0, 159, 1'b0);
        send_range(8'd2, 0, 159, 1'b0);
        send_range(8'hA3, 0, 99, 1'b0);
        check("short_pre_err", 32'(line_err_out), 32'd0);
        send_range(8'd3, 0, 0, 1'b0);
        check("short_err", 32'(line_err_out), 32'd1);
        check("short_busy", 32'(busybuff_out), 32'd3);
        check("short_filled", 32'(filledbuff_out), 32'd2);
        send_range(8'd3, 1, 159, 1'b0);
        check("short_done_filled", 32'(filledbuff_out), 32'd3);
        check("short_done_busy", 32'(busybuff_out), 32'd0);
        nbuff_in  = 9'd3;
        npixel_in = 9'd10;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("short_rewrite", 32'(pixel_out), 32'h00030A);
        clr_err_in = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        clr_err_in = 1'b0;
        check("short_clr", 32'(line_err_out), 32'd0);

        clr_err_in = 1'b1;
        drive(1'b1, 24'h000BAD, 1'b0, 1'b0);
        check("gap_err_wins", 32'(line_err_out), 32'd1);
        check("gap_busy", 32'(busybuff_out), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        clr_err_in = 1'b0;
        check("gap_clr", 32'(line_err_out), 32'd0);
        send_range(8'd4, 0, 159, 1'b0);
        check("gap_next_filled", 32'(filledbuff_out), 32'd0);
        nbuff_in  = 9'd0;
        npixel_in = 9'd0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("gap_intact", 32'(pixel_out), 32'h000400);

        send_range(8'd5, 0, 4, 1'b0);
        nbuff_in  = 9'd1;
        npixel_in = 9'd5;
        send_range(8'd5, 5, 5, 1'b0);
        check("rw_old", 32'(pixel_out), 32'h000105);
        send_range(8'd5, 6, 6, 1'b0);
        check("rw_new", 32'(pixel_out), 32'h000505);
        send_range(8'd5, 7, 159, 1'b0);
        check("l5_filled", 32'(filledbuff_out), 32'd1);
        check("l5_busy", 32'(busybuff_out), 32'd2);

        send_range(8'd6, 0, 9, 1'b0);
        drive(1'b1, 24'h000700, 1'b1, 1'b1);
        check("restart_err", 32'(line_err_out), 32'd1);
        check("restart_busy", 32'(busybuff_out), 32'd0);
        check("restart_filled", 32'(filledbuff_out), 32'd1);
        check("restart_fa", 32'(frame_active_out), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/lepton_line_buffer.md
Name: lepton_line_buffer

Overview:
- Upstream neighbour of LCD_output: a ring of NBUFFERS line buffers between the stereo-Lepton pixel formatter and the LCD writer.
- Accepts a streamed 24-bit RGB pixel stream with start-of-frame and start-of-line markers, and writes each line into the next buffer in the ring.
- Publishes the index of the buffer being written and the index of the last completed buffer, plus a frame-sync pulse.
- Serves random-access reads addressed by buffer index and pixel index with 1-cycle latency.

Parameters:
- HSIZE, 160, pixels per source line; must equal LCD HSIZE/HUPSCALE.
- VSIZE, 120, lines per frame; must equal LCD VSIZE/VUPSCALE.
- NBUFFERS, 4, number of line buffers in the ring; must match LCD NBUFFERS.
- IDX_W, 9, width of the buffer and pixel index ports.

Ports:
- clk_in, input, 1, system clock.
- reset_n_in, input, 1, asynchronous, active-low reset.
- pix_valid_in, input, 1, pixel qualifier.
- pix_data_in, input, 24, RGB888 pixel.
- sof_in, input, 1, first pixel of frame; valid only with pix_valid_in.
- sol_in, input, 1, first pixel of line; valid only with pix_valid_in.
- nbuff_in, input, IDX_W, read buffer index.
- npixel_in, input, IDX_W, read pixel index.
- clr_err_in, input, 1, clears the sticky error flags.
- pixel_out, output, 24, read data.
- busybuff_out, output, IDX_W, buffer currently being or next to be written.
- filledbuff_out, output, IDX_W, last completed buffer.
- fsync_out, output, 1, 1-cycle pulse when line 0 of a frame completes.
- frame_active_out, output, 1, high from sof until line VSIZE-1 completes.
- line_err_out, output, 1, sticky malformed-line flag.

Behaviour:
- Reset values (async assert; release synchronised to clk_in):
  - pixel_out=0, busybuff_out=0, filledbuff_out=NBUFFERS-1.
  - fsync_out=0, frame_active_out=0, line_err_out=0.
  - Internal wpix=0, line_cnt=0, state IDLE.
  - RAM contents are not reset.
- Write FSM states are IDLE, FILL and GAP.
- IDLE:
  - Waits for pix_valid_in&sof_in.
  - On that pixel: busybuff_out<=0, write pixel at (0,0), wpix<=1, line_cnt<=0, frame_active_out<=1, go to FILL.
  - All other pixels are ignored and do not set an error.
- FILL, pix_valid_in & !sol_in:
  - Write at (busybuff_out, wpix), then wpix++.
  - When the pixel written is wpix==HSIZE-1, the line completes:
    - filledbuff_out<=busybuff_out.
    - busybuff_out<=(busybuff_out==NBUFFERS-1)?0:busybuff_out+1.
    - line_cnt++.
    - fsync_out<=1 for one cycle if line_cnt==0.
    - Next state is GAP, or IDLE with frame_active_out<=0 if line_cnt==VSIZE-1.
- FILL, pix_valid_in&sol_in (short line):
  - Set line_err_out.
  - Restart the same buffer: write at wpix 0, wpix<=1.
  - filledbuff_out and busybuff_out do not change.
- GAP:
  - pix_valid_in&sol_in writes at (busybuff_out,0), wpix<=1, go to FILL.
  - pix_valid_in without sol_in: the pixel is dropped and line_err_out is set.
- sof_in in FILL or GAP (frame restart):
  - Set line_err_out if the current line count is not VSIZE.
  - Apply the IDLE sof action; filledbuff_out is not changed.
- Read path:
  - pixel_out <= mem[nbuff_in*HSIZE+npixel_in], registered, 1-cycle latency.
  - If nbuff_in>=NBUFFERS or npixel_in>=HSIZE, pixel_out<=0.
  - When a read and a write hit the same address in the same cycle, the read returns the old data.
- Flow control:
  - The writer never stalls; the camera cannot be back-pressured.
  - The LCD writer waits while nbuff==busybuff_out and nbuff!=filledbuff_out.
- Errors:
  - clr_err_in clears line_err_out.
  - If clr_err_in and a new error occur in the same cycle, the error wins.
- Address arithmetic: product nbuff*HSIZE computed at ceil(log2(NBUFFERS*HSIZE)) bits; no truncation allowed.

Decomposition:
- Package lepton_lb_pkg holds:
  - The FSM state encodings (IDLE/FILL/GAP).
  - Default HSIZE/VSIZE/NBUFFERS constants shared with the LCD top.
  - A function computing the address width.
- Sub-module line_ram: simple dual-port RAM of NBUFFERS*HSIZE x 24, with a synchronous write port and a registered read port (read-old-data).

Test Plan:
- Reset mid-line (assert reset_n_in with wpix=50):
  - All outputs return to their reset values asynchronously.
  - The next sof starts cleanly in buffer 0.
- Full frame of 120 lines x 160 pixels:
  - fsync_out pulses exactly once, 1 cycle after pixel 159 of line 0.
  - filledbuff_out sequence is 0,1,2,3,0,...
  - After line 119, filledbuff_out=3 (119 mod 4), busybuff_out=0 and frame_active_out=0.
- Readback with pixel=(line<<8)|x:
  - nbuff_in=2, npixel_in=17 after line 6 completes returns 0x000611 on the next cycle.
  - npixel_in=160 returns 0.
- Short line (sol after 100 pixels in line 3):
  - line_err_out=1.
  - busybuff_out stays 3 and line 3 is rewritten.
  - clr_err_in returns line_err_out to 0.
- Gap pixel (pix_valid without sol in GAP):
  - The pixel is dropped, line_err_out=1.
  - The next line's data is intact at index 0.
- Same-cycle read/write of (1,5):
  - pixel_out shows the old value.
  - A read in the following cycle shows the new value.
